// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO issue controller: op codes, FSM states, default latencies.
package md_pkg;

   localparam int unsigned OP_W_DEF        = 4;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 32;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/md_countdown.sv
// Loadable down-counter that saturates at zero; flags both "at zero" and "one step from zero".
module md_countdown
   import md_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         one
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
   assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/md_issue.sv
// md_issue: E-stage issue controller for the HI/LO multiply/divide unit.
// Optional build macro MD_DIVZERO_TRAP_EN: div/divu by zero is consumed locally and pulses divz.
module md_issue
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int unsigned OP_W        = OP_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            e_valid,
   input  logic [OP_W-1:0] e_op,
   input  logic [31:0]     e_rs,
   input  logic [31:0]     e_rt,
   input  logic            md_busy,
   output logic            e_stall,
   output logic            md_start,
   output logic [OP_W-1:0] md_op,
   output logic [31:0]     md_a,
   output logic [31:0]     md_b,
   output logic            mf_valid,
   output logic            mf_sel,
   output logic            divz
);

   localparam logic [OP_W-1:0] K_NONE  = OP_W'(OP_NONE);
   localparam logic [OP_W-1:0] K_MULT  = OP_W'(OP_MULT);
   localparam logic [OP_W-1:0] K_MULTU = OP_W'(OP_MULTU);
   localparam logic [OP_W-1:0] K_DIV   = OP_W'(OP_DIV);
   localparam logic [OP_W-1:0] K_DIVU  = OP_W'(OP_DIVU);
   localparam logic [OP_W-1:0] K_MTHI  = OP_W'(OP_MTHI);
   localparam logic [OP_W-1:0] K_MTLO  = OP_W'(OP_MTLO);
   localparam logic [OP_W-1:0] K_MFHI  = OP_W'(OP_MFHI);
   localparam logic [OP_W-1:0] K_MFLO  = OP_W'(OP_MFLO);

   function automatic logic is_mul(input logic [OP_W-1:0] op);
      return (op == K_MULT) || (op == K_MULTU);
   endfunction

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op == K_DIV) || (op == K_DIVU);
   endfunction

   function automatic logic is_mt(input logic [OP_W-1:0] op);
      return (op == K_MTHI) || (op == K_MTLO);
   endfunction

   function automatic logic is_mf(input logic [OP_W-1:0] op);
      return (op == K_MFHI) || (op == K_MFLO);
   endfunction

   state_e            state_q, state_d;
   logic              md_start_q, md_start_d;
   logic [OP_W-1:0]   md_op_q, md_op_d;
   logic [31:0]       md_a_q, md_a_d;
   logic [31:0]       md_b_q, md_b_d;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_dec;
   logic              cnt_zero;
   logic              cnt_one;
   logic              md_class;

   assign md_class = e_valid && (e_op != K_NONE);

`ifdef MD_DIVZERO_TRAP_EN
   logic divz_q, divz_d;
`endif

   md_countdown #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero),
      .one      (cnt_one)
   );

   always_comb begin
      state_d    = state_q;
      md_start_d = 1'b0;
      md_op_d    = md_op_q;
      md_a_d     = md_a_q;
      md_b_d     = md_b_q;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      cnt_dec    = 1'b0;
      e_stall    = 1'b0;
      mf_valid   = 1'b0;
      mf_sel     = 1'b0;
`ifdef MD_DIVZERO_TRAP_EN
      divz_d     = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (md_class) begin
               if (md_busy) begin
                  e_stall = 1'b1;
               end else if (is_mf(e_op)) begin
                  mf_valid = 1'b1;
                  mf_sel   = (e_op == K_MFHI);
`ifdef MD_DIVZERO_TRAP_EN
               end else if (is_div(e_op) && (e_rt == '0)) begin
                  divz_d = 1'b1;
`endif
               end else if (is_mul(e_op) || is_div(e_op) || is_mt(e_op)) begin
                  state_d    = ST_ISSUE;
                  md_start_d = 1'b1;
                  md_op_d    = e_op;
                  md_a_d     = e_rs;
                  md_b_d     = e_rt;
               end
            end
         end
         ST_ISSUE: begin
            e_stall = md_class;
            if (is_mul(md_op_q)) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(MULT_CYCLES);
               state_d  = ST_WAIT;
            end else if (is_div(md_op_q)) begin
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(DIV_CYCLES);
               state_d  = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            e_stall = md_class;
            cnt_dec = 1'b1;
            // Count reaches zero at this edge (or already did); HI/LO also needs the unit idle.
            if ((cnt_zero || cnt_one) && !md_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         md_start_q <= 1'b0;
         md_op_q    <= '0;
         md_a_q     <= '0;
         md_b_q     <= '0;
      end else begin
         state_q    <= state_d;
         md_start_q <= md_start_d;
         md_op_q    <= md_op_d;
         md_a_q     <= md_a_d;
         md_b_q     <= md_b_d;
      end
   end

`ifdef MD_DIVZERO_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divz_q <= 1'b0;
      end else begin
         divz_q <= divz_d;
      end
   end
   assign divz = divz_q;
`else
   assign divz = 1'b0;
`endif

   assign md_start = md_start_q;
   assign md_op    = md_op_q;
   assign md_a     = md_a_q;
   assign md_b     = md_b_q;

endmodule

// File: tb/tb_md_issue.sv
// Self-checking bench for md_issue: directed table, hand-written corner sequences, random vs model.
module tb_md_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_valid;
   logic [3:0]  e_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        md_busy;
   logic        e_stall;
   logic        md_start;
   logic [3:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        mf_valid;
   logic        mf_sel;
   logic        divz;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: time-based view of the single in-flight operation
   bit          m_free;
   int          m_tacc;
   int          m_lat;
   logic [3:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;
   bit          m_divz;

   bit o_stall, o_start, o_mfv, o_sel, o_divz;

   md_issue #(.MULT_CYCLES(5), .DIV_CYCLES(10), .OP_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .e_valid  (e_valid),
      .e_op     (e_op),
      .e_rs     (e_rs),
      .e_rt     (e_rt),
      .md_busy  (md_busy),
      .e_stall  (e_stall),
      .md_start (md_start),
      .md_op    (md_op),
      .md_a     (md_a),
      .md_b     (md_b),
      .mf_valid (mf_valid),
      .mf_sel   (mf_sel),
      .divz     (divz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_free = 1'b1;
      m_tacc = -100;
      m_lat  = 0;
      m_op   = '0;
      m_a    = '0;
      m_b    = '0;
      m_divz = 1'b0;
   endtask

   // Called just after a rising edge: drive inputs, check at the falling edge, advance model.
   task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input bit busy);
      bit md, mf, launch, trap, acc, x_stall, x_mfv, x_start;
      e_valid = v;
      e_op    = op;
      e_rs    = rs;
      e_rt    = rt;
      md_busy = busy;
      md      = v && (op != 4'd0);
      mf      = v && (op == 4'd7 || op == 4'd8);
      launch  = v && (op >= 4'd1) && (op <= 4'd6);
      trap    = 1'b0;
`ifdef MD_DIVZERO_TRAP_EN
      trap    = launch && (op == 4'd3 || op == 4'd4) && (rt == 32'd0);
`endif
      x_stall = md && (!m_free || busy);
      x_mfv   = mf && m_free && !busy;
      x_start = !m_free && (cyc == m_tacc + 1);
      acc     = m_free && !busy && launch && !trap;
      @(negedge clk);
      o_stall = e_stall;
      o_start = md_start;
      o_mfv   = mf_valid;
      o_sel   = mf_sel;
      o_divz  = divz;
      chk("e_stall", 32'(e_stall), 32'(x_stall));
      chk("md_start", 32'(md_start), 32'(x_start));
      chk("mf_valid", 32'(mf_valid), 32'(x_mfv));
      if (x_mfv) chk("mf_sel", 32'(mf_sel), 32'(op == 4'd7));
      chk("md_op", 32'(md_op), 32'(m_op));
      chk("md_a", md_a, m_a);
      chk("md_b", md_b, m_b);
      chk("divz", 32'(divz), 32'(m_divz));
      @(posedge clk);
      m_divz = m_free && !busy && trap;
      if (acc) begin
         m_free = 1'b0;
         m_tacc = cyc;
         m_lat  = (op == 4'd1 || op == 4'd2) ? 5 : (op == 4'd3 || op == 4'd4) ? 10 : 0;
         m_op   = op;
         m_a    = rs;
         m_b    = rt;
      end else if (!m_free && (cyc >= m_tacc + 1 + m_lat) && (m_lat == 0 || !busy)) begin
         m_free = 1'b1;
      end
      cyc++;
      #1;
   endtask

   typedef struct {
      bit          v;
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      bit          busy;
      bit          x_stall;
      bit          x_start;
      bit          x_mfv;
      bit          x_sel;
   } vec_t;

   vec_t vt[10];

   initial begin
      // mult 3*7 then an mflo held in E until HI/LO settles
      vt[0] = '{1'b1, 4'd1, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 2; i <= 6; i++) vt[i] = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7] = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[8] = '{1'b1, 4'd7, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset   = 1'b0;
      e_valid = 1'b1;
      e_op    = 4'd7;
      e_rs    = '0;
      e_rt    = '0;
      md_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_md_start", 32'(md_start), 32'd0);
      chk("rst_md_op", 32'(md_op), 32'd0);
      chk("rst_md_a", md_a, 32'd0);
      chk("rst_md_b", md_b, 32'd0);
      chk("rst_divz", 32'(divz), 32'd0);
      chk("rst_e_stall", 32'(e_stall), 32'd0);
      chk("rst_mf_valid", 32'(mf_valid), 32'd1);
      chk("rst_mf_sel", 32'(mf_sel), 32'd1);
      reset = 1'b1;
      model_reset();

      for (int i = 0; i < 10; i++) begin
         cycle(vt[i].v, vt[i].op, vt[i].rs, vt[i].rt, vt[i].busy);
         chk("tbl_stall", 32'(o_stall), 32'(vt[i].x_stall));
         chk("tbl_start", 32'(o_start), 32'(vt[i].x_start));
         chk("tbl_mfv", 32'(o_mfv), 32'(vt[i].x_mfv));
         if (vt[i].x_mfv) chk("tbl_sel", 32'(o_sel), 32'(vt[i].x_sel));
         if (i == 1) begin
            chk("tbl_md_a", md_a, 32'd3);
            chk("tbl_md_b", md_b, 32'd7);
            chk("tbl_md_op", 32'(md_op), 32'd1);
         end
      end

      // divu with the unit busy past the count: HI/LO frees only when busy drops
      cycle(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         cycle(1'b1, 4'd7, 32'd0, 32'd0, k <= 14);
         chk("divu_stall", 32'(o_stall), 32'(k <= 15));
         chk("divu_mfv", 32'(o_mfv), 32'(k == 16));
         chk("divu_start", 32'(o_start), 32'(k == 1));
      end
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

      // mthi then mtlo back to back
      cycle(1'b1, 4'd5, 32'hDEADBEEF, 32'd0, 1'b0);
      cycle(1'b1, 4'd6, 32'h00001234, 32'd0, 1'b0);
      chk("mt_stall1", 32'(o_stall), 32'd1);
      chk("mt_start1", 32'(o_start), 32'd1);
      chk("mt_a1", md_a, 32'hDEADBEEF);
      cycle(1'b1, 4'd6, 32'h00001234, 32'd0, 1'b0);
      chk("mt_stall2", 32'(o_stall), 32'd0);
      chk("mt_start2", 32'(o_start), 32'd0);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mt_start3", 32'(o_start), 32'd1);
      chk("mt_op3", 32'(md_op), 32'd6);
      chk("mt_a3", md_a, 32'h00001234);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

      // non-md instructions flow freely while a mult is in flight
      cycle(1'b1, 4'd2, 32'd9, 32'd9, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b1, 4'd0, 32'(k), 32'(k), 1'b0);
         chk("addu_stall", 32'(o_stall), 32'd0);
      end

      // reset in WAIT (count at 3) abandons the mult
      cycle(1'b1, 4'd1, 32'd11, 32'd13, 1'b0);
      for (int k = 1; k <= 3; k++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      e_valid = 1'b1;
      e_op    = 4'd8;
      md_busy = 1'b0;
      reset   = 1'b0;
      #2;
      chk("mid_rst_md_a", md_a, 32'd0);
      chk("mid_rst_md_op", 32'(md_op), 32'd0);
      chk("mid_rst_start", 32'(md_start), 32'd0);
      chk("mid_rst_stall", 32'(e_stall), 32'd0);
      chk("mid_rst_mfv", 32'(mf_valid), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      cyc++;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
         chk("post_rst_start", 32'(o_start), 32'd0);
      end

      // divide by zero
      cycle(1'b1, 4'd3, 32'd5, 32'd0, 1'b0);
      chk("dz_stall0", 32'(o_stall), 32'd0);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
`ifdef MD_DIVZERO_TRAP_EN
      chk("dz_start", 32'(o_start), 32'd0);
      chk("dz_divz", 32'(o_divz), 32'd1);
      cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("dz_divz_off", 32'(o_divz), 32'd0);
`else
      chk("dz_start", 32'(o_start), 32'd1);
      chk("dz_divz", 32'(o_divz), 32'd0);
      chk("dz_md_b", md_b, 32'd0);
`endif
      for (int k = 0; k < 14; k++) cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

      // random traffic; a stalled instruction is held in E
      begin
         bit          r_v;
         logic [3:0]  r_op;
         logic [31:0] r_rs;
         logic [31:0] r_rt;
         bit          r_busy;
         r_v = 1'b0;
         r_op = '0;
         r_rs = '0;
         r_rt = '0;
         for (int n = 0; n < 600; n++) begin
            if (!(o_stall && n > 0)) begin
               r_v  = ($urandom_range(0, 3) != 0);
               r_op = 4'($urandom_range(0, 8));
               r_rs = $urandom;
               r_rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            end
            r_busy = ($urandom_range(0, 3) == 0);
            cycle(r_v, r_op, r_rs, r_rt, r_busy);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
